snake_head_step: RTL and testbench



---
 rtl/snake_pkg.sv | 40 ++++
 rtl/snake_grid_step.sv | 70 +++++++
 rtl/snake_head_step.sv | 138 +++++++++++++
 tb/tb_snake_head_step.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake game datapath.
//   direction : steering / step direction (UP, DOWN, LEFT, RIGHT)
//   game_mode : top-level game mode; only GAME lets the head move
//   opposite(): returns the 180-degree reverse of a direction
//   ST_*      : head-step FSM state encodings
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } direction;

  typedef enum logic [1:0] {
    MENU = 2'd0,
    GAME = 2'd1,
    OVER = 2'd2
  } game_mode;

  localparam int DEFAULT_GRID_W = 32;
  localparam int DEFAULT_GRID_H = 24;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_TICK = 2'd1;
  localparam logic [1:0] ST_REQ       = 2'd2;
  localparam logic [1:0] ST_HALT      = 2'd3;

  function automatic direction opposite(input direction d);
    direction r;
    case (d)
      UP:      r = DOWN;
      DOWN:    r = UP;
      LEFT:    r = RIGHT;
      default: r = LEFT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snake_grid_step.sv
// Combinational next-cell computation for one head step.
// Ports:
//   x, y     : current head cell
//   a        : direction to apply (already reversal-guarded)
//   nx, ny   : next head cell (equal to x, y when off_grid)
//   off_grid : step would leave the board and WRAP is 0
// Edges are compared explicitly so non-power-of-2 boards wrap correctly.
module snake_grid_step
  import snake_pkg::*;
#(
  parameter int GRID_W = DEFAULT_GRID_W,
  parameter int GRID_H = DEFAULT_GRID_H,
  parameter int WRAP   = 1,
  parameter int XW     = $clog2(GRID_W),
  parameter int YW     = $clog2(GRID_H)
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  direction      a,
  output logic [XW-1:0] nx,
  output logic [YW-1:0] ny,
  output logic          off_grid
);

  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);

  always_comb begin
    nx       = x;
    ny       = y;
    off_grid = 1'b0;
    case (a)
      UP: begin
        if (y == '0) begin
          if (WRAP != 0) ny = Y_MAX;
          else           off_grid = 1'b1;
        end else begin
          ny = y - Y_ONE;
        end
      end
      DOWN: begin
        if (y == Y_MAX) begin
          if (WRAP != 0) ny = '0;
          else           off_grid = 1'b1;
        end else begin
          ny = y + Y_ONE;
        end
      end
      LEFT: begin
        if (x == '0) begin
          if (WRAP != 0) nx = X_MAX;
          else           off_grid = 1'b1;
        end else begin
          nx = x - X_ONE;
        end
      end
      default: begin
        if (x == X_MAX) begin
          if (WRAP != 0) nx = '0;
          else           off_grid = 1'b1;
        end else begin
          nx = x + X_ONE;
        end
      end
    endcase
  end

endmodule

// File: rtl/snake_head_step.sv
// Snake head stepper: advances the head one cell per rising edge of the
// game tick while in GAME mode, and hands each new position to the board
// writer over a req/ack handshake.
// Ports:
//   clk, rst     : clock; synchronous active-low reset
//   clk_divided  : game tick level; its rising edge triggers a step
//   mode         : game mode; anything but GAME returns to IDLE and reloads
//   dir          : requested direction from steering
//   board_ack    : board writer consumed the pending step (used only in REQ)
//   head_x/y     : current head cell
//   step_dir     : direction applied by the last step
//   step_req     : new head valid, held until acked
//   wall_hit     : sticky, head tried to leave the grid with WRAP=0
//   overrun      : sticky, a tick arrived while a step was still pending
//   step_cnt     : count of acked steps (wraps)
module snake_head_step
  import snake_pkg::*;
#(
  parameter int GRID_W  = DEFAULT_GRID_W,
  parameter int GRID_H  = DEFAULT_GRID_H,
  parameter int START_X = 16,
  parameter int START_Y = 12,
  parameter int WRAP    = 1,
  parameter int XW      = $clog2(GRID_W),
  parameter int YW      = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_divided,
  input  game_mode      mode,
  input  direction      dir,
  input  logic          board_ack,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output direction      step_dir,
  output logic          step_req,
  output logic          wall_hit,
  output logic          overrun,
  output logic [15:0]   step_cnt
);

  localparam logic [XW-1:0] X_START = XW'(START_X);
  localparam logic [YW-1:0] Y_START = YW'(START_Y);

  logic [1:0]    state;
  logic          tick_prev;
  logic          tick;
  direction      applied;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic          off_grid;

  assign tick = !tick_prev && clk_divided;

  // A request for the exact reverse would fold the snake onto itself, so
  // keep going the current way instead.
  assign applied = (dir == opposite(step_dir)) ? step_dir : dir;

  snake_grid_step #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .WRAP   (WRAP),
    .XW     (XW),
    .YW     (YW)
  ) u_grid_step (
    .x        (head_x),
    .y        (head_y),
    .a        (applied),
    .nx       (nx),
    .ny       (ny),
    .off_grid (off_grid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_x    <= X_START;
      head_y    <= Y_START;
      step_dir  <= UP;
      step_req  <= 1'b0;
      wall_hit  <= 1'b0;
      overrun   <= 1'b0;
      step_cnt  <= 16'd0;
      state     <= ST_IDLE;
      tick_prev <= 1'b0;
    end else begin
      // Edge history runs in every state so the first tick after entering
      // GAME is seen as a clean rising edge.
      tick_prev <= clk_divided;
      if (mode != GAME) begin
        head_x   <= X_START;
        head_y   <= Y_START;
        step_dir <= UP;
        step_req <= 1'b0;
        wall_hit <= 1'b0;
        overrun  <= 1'b0;
        step_cnt <= 16'd0;
        state    <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_WAIT_TICK;
          end
          ST_WAIT_TICK: begin
            if (tick) begin
              step_dir <= applied;
              if (off_grid) begin
                wall_hit <= 1'b1;
                state    <= ST_HALT;
              end else begin
                head_x   <= nx;
                head_y   <= ny;
                step_req <= 1'b1;
                state    <= ST_REQ;
              end
            end
          end
          ST_REQ: begin
            // Ticks during a pending step are flagged and discarded, even
            // when the ack lands on the same edge.
            if (tick) begin
              overrun <= 1'b1;
            end
            if (board_ack) begin
              step_req <= 1'b0;
              step_cnt <= step_cnt + 16'd1;
              state    <= ST_WAIT_TICK;
            end
          end
          default: begin
            // HALT: frozen until mode leaves GAME.
            state <= ST_HALT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snake_head_step.sv
module tb_snake_head_step;
  import snake_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_divided;
  game_mode    mode, mode_w;
  direction    dir;
  logic        board_ack;

  logic [4:0]  hx, hy, hx_w, hy_w;
  direction    sd, sd_w;
  logic        req, req_w, wall, wall_w, ov, ov_w;
  logic [15:0] cnt, cnt_w;

  logic        sel;
  logic [4:0]  hx_s, hy_s;
  direction    sd_s;
  logic        req_s, wall_s, ov_s;
  logic [15:0] cnt_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int       x;
    int       y;
    direction d;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    direction d;
    int       ex;
    int       ey;
    direction ed;
  } vec_t;
  vec_t tbl[8];

  int       m_x, m_y, m_cnt;
  direction m_dir;

  always #5 clk = ~clk;

  snake_head_step #(.WRAP(1)) dut (
    .clk(clk), .rst(rst), .clk_divided(clk_divided), .mode(mode), .dir(dir),
    .board_ack(board_ack), .head_x(hx), .head_y(hy), .step_dir(sd),
    .step_req(req), .wall_hit(wall), .overrun(ov), .step_cnt(cnt)
  );

  snake_head_step #(.WRAP(0)) dut_w (
    .clk(clk), .rst(rst), .clk_divided(clk_divided), .mode(mode_w), .dir(dir),
    .board_ack(board_ack), .head_x(hx_w), .head_y(hy_w), .step_dir(sd_w),
    .step_req(req_w), .wall_hit(wall_w), .overrun(ov_w), .step_cnt(cnt_w)
  );

  always_comb begin
    hx_s = hx; hy_s = hy; sd_s = sd; req_s = req; wall_s = wall; ov_s = ov; cnt_s = cnt;
    if (sel) begin
      hx_s = hx_w; hy_s = hy_w; sd_s = sd_w; req_s = req_w;
      wall_s = wall_w; ov_s = ov_w; cnt_s = cnt_w;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 16; m_y = 12; m_dir = UP; m_cnt = 0;
  endtask

  // Reference step: reversal rejected by pairing on the encoding, wrap by modulo.
  task automatic model_next(input direction d, output int ex, output int ey, output direction ed);
    logic [1:0] dv, mv;
    dv = d; mv = m_dir;
    ed = ((dv[1] == mv[1]) && (dv[0] != mv[0])) ? m_dir : d;
    ex = m_x; ey = m_y;
    case (ed)
      UP:      ey = (m_y + 24 - 1) % 24;
      DOWN:    ey = (m_y + 1) % 24;
      LEFT:    ex = (m_x + 32 - 1) % 32;
      default: ex = (m_x + 1) % 32;
    endcase
  endtask

  task automatic do_step(input direction d, input int ex, input int ey, input direction ed);
    exp_t e;
    int   n;
    @(negedge clk);
    dir = d; clk_divided = 1'b1;
    e.x = ex; e.y = ey; e.d = ed;
    sb.push_back(e);
    @(negedge clk);
    clk_divided = 1'b0;
    n = 0;
    while (!req_s && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!req_s) begin
      checks++; errors++;
      $display("FAIL step_req_timeout: got 0 expected 1 within 8 cycles");
      void'(sb.pop_front());
    end else begin
      chk("req_latency", n, 0);
      e = sb.pop_front();
      chk("head_x", int'(hx_s), e.x);
      chk("head_y", int'(hy_s), e.y);
      chk("step_dir", int'(sd_s), int'(e.d));
      board_ack = 1'b1;
      @(negedge clk);
      board_ack = 1'b0;
      m_cnt++;
      chk("req_drop", int'(req_s), 0);
      chk("step_cnt", int'(cnt_s), m_cnt);
    end
    m_x = ex; m_y = ey; m_dir = ed;
  endtask

  task automatic walk(input direction d, input int n);
    int ex, ey;
    direction ed;
    for (int i = 0; i < n; i++) begin
      model_next(d, ex, ey, ed);
      do_step(d, ex, ey, ed);
    end
  endtask

  task automatic mode_cycle();
    @(negedge clk); mode = MENU;
    @(negedge clk); mode = GAME;
    @(negedge clk);
    model_reset();
  endtask

  task automatic tick_only();
    @(negedge clk); clk_divided = 1'b1;
    @(negedge clk); clk_divided = 1'b0;
  endtask

  initial begin
    tbl[0] = '{RIGHT, 17, 11, RIGHT};
    tbl[1] = '{LEFT,  18, 11, RIGHT};
    tbl[2] = '{UP,    18, 10, UP};
    tbl[3] = '{DOWN,  18,  9, UP};
    tbl[4] = '{LEFT,  17,  9, LEFT};
    tbl[5] = '{RIGHT, 16,  9, LEFT};
    tbl[6] = '{DOWN,  16, 10, DOWN};
    tbl[7] = '{UP,    16, 11, DOWN};

    sel = 1'b0; rst = 1'b0; clk_divided = 1'b0; mode = MENU; mode_w = MENU;
    dir = UP; board_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_head_x", int'(hx), 16);
    chk("rst_head_y", int'(hy), 12);
    chk("rst_step_dir", int'(sd), int'(UP));
    chk("rst_req", int'(req), 0);
    chk("rst_wall", int'(wall), 0);
    chk("rst_overrun", int'(ov), 0);
    chk("rst_cnt", int'(cnt), 0);

    // First step: ack two cycles after the tick.
    rst = 1'b1; mode = GAME;
    @(negedge clk);
    dir = RIGHT; clk_divided = 1'b1;
    @(negedge clk);
    clk_divided = 1'b0;
    chk("t1_req_c1", int'(req), 1);
    chk("t1_head_x", int'(hx), 17);
    chk("t1_head_y", int'(hy), 12);
    @(negedge clk);
    chk("t1_req_c2", int'(req), 1);
    board_ack = 1'b1;
    @(negedge clk);
    board_ack = 1'b0;
    chk("t1_req_off", int'(req), 0);
    chk("t1_cnt", int'(cnt), 1);
    chk("t1_step_dir", int'(sd), int'(RIGHT));

    // Reversal from fresh UP.
    mode_cycle();
    chk("menu_head_x", int'(hx), 16);
    chk("menu_cnt", int'(cnt), 0);
    do_step(DOWN, 16, 11, UP);

    for (int i = 0; i < 8; i++) do_step(tbl[i].d, tbl[i].ex, tbl[i].ey, tbl[i].ed);

    // Wrap at the right and top edges.
    mode_cycle();
    walk(RIGHT, 15);
    walk(UP, 7);
    do_step(RIGHT, 0, 5, RIGHT);
    walk(RIGHT, 4);
    walk(UP, 5);
    do_step(UP, 4, 23, UP);

    // Wall death on the WRAP=0 instance.
    @(negedge clk); mode = MENU; mode_w = GAME; sel = 1'b1;
    @(negedge clk);
    model_reset();
    walk(LEFT, 16);
    walk(UP, 5);
    @(negedge clk); dir = LEFT; clk_divided = 1'b1;
    @(negedge clk); clk_divided = 1'b0;
    chk("wall_hit", int'(wall_w), 1);
    chk("wall_req", int'(req_w), 0);
    chk("wall_head_x", int'(hx_w), 0);
    chk("wall_head_y", int'(hy_w), 7);
    chk("wall_step_dir", int'(sd_w), int'(LEFT));
    dir = RIGHT;
    tick_only();
    repeat (2) @(negedge clk);
    chk("halt_head_x", int'(hx_w), 0);
    chk("halt_req", int'(req_w), 0);
    chk("halt_step_dir", int'(sd_w), int'(LEFT));
    mode_w = MENU;
    @(negedge clk);
    chk("unhalt_head_x", int'(hx_w), 16);
    chk("unhalt_head_y", int'(hy_w), 12);
    chk("unhalt_wall", int'(wall_w), 0);
    sel = 1'b0;

    // Overrun: two ticks while the request is pending.
    mode_cycle();
    dir = RIGHT;
    tick_only();
    chk("ov_req", int'(req), 1);
    tick_only();
    tick_only();
    chk("ov_flag", int'(ov), 1);
    chk("ov_head_x", int'(hx), 17);
    chk("ov_req_held", int'(req), 1);
    @(negedge clk); board_ack = 1'b1;
    @(negedge clk); board_ack = 1'b0;
    chk("ov_cnt", int'(cnt), 1);
    chk("ov_sticky", int'(ov), 1);

    // Ack and tick on the same edge: ack taken, tick dropped.
    mode_cycle();
    chk("ov_cleared", int'(ov), 0);
    dir = RIGHT;
    tick_only();
    chk("same_req", int'(req), 1);
    @(negedge clk); board_ack = 1'b1; clk_divided = 1'b1;
    @(negedge clk); board_ack = 1'b0; clk_divided = 1'b0;
    chk("same_req_off", int'(req), 0);
    chk("same_cnt", int'(cnt), 1);
    chk("same_ov", int'(ov), 1);
    repeat (3) @(negedge clk);
    chk("same_dropped_req", int'(req), 0);
    chk("same_dropped_x", int'(hx), 17);

    // Reset in the middle of a handshake.
    tick_only();
    chk("mid_req", int'(req), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", int'(req), 0);
    chk("mid_rst_x", int'(hx), 16);
    chk("mid_rst_y", int'(hy), 12);
    chk("mid_rst_cnt", int'(cnt), 0);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    do_step(RIGHT, 17, 12, RIGHT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
